// File: rtl/serial_rx6_pkg.sv
// Shared definitions for the 6-byte UART link (TX and RX sides).
package serial_rx6_pkg;
  localparam int PKT_BYTES = 6;
  localparam int PKT_W     = 8 * PKT_BYTES;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    STOP_BIT  = 3'd3,
    GAP       = 3'd4
  } rx_state_e;
endpackage

// File: rtl/serial_rx6_if.sv
// Serial line in, packet word and status strobes out.
// slave: the receiver; master: whatever drives the line and consumes packets.
interface serial_rx6_if;
  logic                           rx;
  logic [serial_rx6_pkg::PKT_W-1:0] data;
  logic                           new_data;
  logic                           busy;
  logic                           frame_err;
  logic                           timeout;

  modport slave  (input  rx, output data, new_data, busy, frame_err, timeout);
  modport master (output rx, input  data, new_data, busy, frame_err, timeout);
endinterface

// File: rtl/serial_rx6_rx_sync_edge.sv
// 2-FF synchronizer for the async serial line plus a 1->0 edge detector.
// All flops reset to the idle (high) level so reset release on an idle line
// never looks like a start edge.
module rx_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);
  logic r_s1, r_s2, r_prev;

  // synchronize, then keep one extra sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_s1   <= i_rx;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_rx_s = r_s2;
  assign o_fall = r_prev & ~r_s2;
endmodule

// File: rtl/serial_rx6.sv
// Receiver for 6-byte 8N1 packets. Assembles bytes LSB-first into a 48-bit
// word (byte 0 in [7:0]); bad stop bits and over-long inter-byte gaps drop
// the whole packet and pulse a flag instead of new_data.
module serial_rx6
  import serial_rx6_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int GAP_BITS    = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_rx6_if.slave bus
);
  localparam int CTR_W = $clog2(CLK_PER_BIT);
  localparam int GAP_W = $clog2(GAP_BITS * CLK_PER_BIT + 1);
  localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_W-1:0] CTR_FULL = CTR_W'(CLK_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_BITS * CLK_PER_BIT);
  localparam logic [2:0]       LAST_BYTE = 3'(PKT_BYTES - 1);

  logic             w_rx_s, w_fall;
  logic [GAP_W-1:0] w_gap_nxt;

  rx_state_e        r_state;
  logic [CTR_W-1:0] r_ctr;
  logic [GAP_W-1:0] r_gap;
  logic [2:0]       r_bit, r_byte;
  logic [PKT_W-1:0] r_shift, r_data;
  logic             r_new_data, r_busy, r_frame_err, r_timeout;

  rx_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (bus.rx),
    .o_rx_s (w_rx_s),
    .o_fall (w_fall)
  );

  // saturating so the counter can never wrap back into a valid gap
  assign w_gap_nxt = (r_gap == GAP_MAX) ? r_gap : r_gap + GAP_W'(1);

  // receive FSM; strobes default low so each is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ctr       <= '0;
      r_gap       <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_new_data  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_new_data  <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_byte <= '0;
          r_ctr  <= '0;
          if (w_fall) begin
            r_state <= START_BIT;
            r_busy  <= 1'b1;
          end
        end
        START_BIT: begin
          if (r_ctr == CTR_HALF) begin
            r_ctr <= '0;
            r_bit <= '0;
            if (w_rx_s) begin
              // line went back high before mid-bit: noise, not a start bit
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_ctr <= r_ctr + CTR_W'(1);
          end
        end
        DATA: begin
          if (r_ctr == CTR_FULL) begin
            r_ctr                   <= '0;
            r_shift[{r_byte, r_bit}] <= w_rx_s;
            r_bit                   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP_BIT;
          end else begin
            r_ctr <= r_ctr + CTR_W'(1);
          end
        end
        STOP_BIT: begin
          if (r_ctr == CTR_FULL) begin
            r_ctr <= '0;
            if (!w_rx_s) begin
              r_frame_err <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else if (r_byte == LAST_BYTE) begin
              r_data     <= r_shift;
              r_new_data <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_byte  <= r_byte + 3'd1;
              r_gap   <= '0;
              r_state <= GAP;
            end
          end else begin
            r_ctr <= r_ctr + CTR_W'(1);
          end
        end
        GAP: begin
          if (w_fall) begin
            r_gap   <= '0;
            r_ctr   <= '0;
            r_state <= START_BIT;
          end else if (w_gap_nxt == GAP_MAX) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_gap <= w_gap_nxt;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.new_data  = r_new_data;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_frame_err;
  assign bus.timeout   = r_timeout;
endmodule
